uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one `uart_transmitter` between NREQ requesters. It sits between the requesters (CPU port, debug monitor, trace unit) and the transmitter's `tx_start`/`data_in`/`tx_ready` ports. Each requester offers one byte at a time over a valid/ready handshake. The arbiter accepts one winner's byte, issues a single-cycle `tx_start`, and then tracks the transmitter through start, data and stop until it returns to idle.

---
 rtl/uart_pkg.sv | 14 +
 rtl/rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 150 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg - shared state encoding and defaults for the UART transmit path.
// Revision 1.0
`default_nettype none
package uart_pkg;

  localparam int DBITS_DEFAULT = 8;

  localparam logic [1:0] ST_ARB       = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
// rr_pick - combinational round-robin pick: first set request after index `last`, cyclically.
// Revision 1.0
`default_nettype none
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic [NREQ-1:0] gnt,
  output logic            any
);

  logic [IDXW:0]     sh;
  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] back;
  logic [NREQ-1:0]   rot;
  logic [NREQ-1:0]   first;

  // Rotate so bit 0 is the index just after `last`, isolate the lowest set bit, rotate back.
  assign sh    = {1'b0, last} + 1'b1;
  assign dbl   = {req, req} >> sh;
  assign rot   = dbl[NREQ-1:0];
  assign first = rot & (~rot + 1'b1);
  assign back  = {{NREQ{1'b0}}, first} << sh;
  assign gnt   = back[NREQ-1:0] | back[2*NREQ-1:NREQ];
  assign any   = |req;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter - round-robin sharing of one uart_transmitter; packet lock when UART_TX_ARB_LOCK_EN is defined.
// Revision 1.0
`default_nettype none
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int DBITS        = DBITS_DEFAULT,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DBITS-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic                  tx_start,
  output logic [DBITS-1:0]      tx_data,
  input  logic                  tx_ready,
  output logic [NREQ-1:0]       grant,
  output logic                  locked
);

  localparam int IDXW = $clog2(NREQ);

  logic [1:0]       state_q, state_d;
  logic [IDXW-1:0]  last_grant_q, last_grant_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [DBITS-1:0] tx_data_q, tx_data_d;
  logic             lock_on;
  logic [NREQ-1:0]  lock_mask, eligible, win_oh;
  logic             win_any, accept;
  logic [IDXW-1:0]  win_idx;

  // While locked, only the requester that took the lock (last winner) may compete.
  assign lock_mask = {{(NREQ-1){1'b0}}, 1'b1} << last_grant_q;
  assign eligible  = lock_on ? (req_valid & lock_mask) : req_valid;

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr_pick (
    .req  (eligible),
    .last (last_grant_q),
    .gnt  (win_oh),
    .any  (win_any)
  );

  assign accept = (state_q == ST_ARB) && tx_ready && win_any;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (win_oh[i]) win_idx = IDXW'(i);
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) state_q <= ST_ARB;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB:       if (accept)    state_d = ST_ISSUE;
      ST_ISSUE:                    state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (!tx_ready) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (tx_ready)  state_d = ST_ARB;
      default:                     state_d = ST_ARB;
    endcase
  end

  always_comb begin
    req_ready = accept ? win_oh : '0;
    tx_start  = (state_q == ST_ISSUE);
  end

  always_comb begin
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    tx_data_d    = tx_data_q;
    if (accept) begin
      last_grant_d = win_idx;
      grant_d      = win_oh;
      tx_data_d    = req_data[win_idx*DBITS +: DBITS];
    end else if ((state_q == ST_WAIT_DONE) && tx_ready) begin
      grant_d = '0;
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      last_grant_q <= IDXW'(NREQ-1);
      grant_q      <= '0;
      tx_data_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      tx_data_q    <= tx_data_d;
    end
  end

  assign grant   = grant_q;
  assign tx_data = tx_data_q;
  assign locked  = lock_on;

`ifdef UART_TX_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_TIMEOUT+1);

  logic          locked_q, locked_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;

  // Idle cycles of the lock owner are counted only while waiting in ARB.
  always_comb begin
    locked_d   = locked_q;
    lock_cnt_d = lock_cnt_q;
    if (accept) begin
      locked_d   = ~req_last[win_idx];
      lock_cnt_d = '0;
    end else if (locked_q && (state_q == ST_ARB) && (eligible == '0)) begin
      if (lock_cnt_q != CW'(LOCK_TIMEOUT)) lock_cnt_d = lock_cnt_q + 1'b1;
      if (lock_cnt_d == CW'(LOCK_TIMEOUT)) begin
        locked_d   = 1'b0;
        lock_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      locked_q   <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      locked_q   <= locked_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign lock_on = locked_q;
`else
  logic [NREQ-1:0] unused_req_last;
  logic [31:0]     unused_lock_timeout;

  assign lock_on             = 1'b0;
  assign unused_req_last     = req_last;
  assign unused_lock_timeout = 32'(LOCK_TIMEOUT);
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter - directed and random checks of uart_tx_arbiter against a transaction-level model.
// Revision 1.0
`default_nettype none
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int DB      = 8;
  localparam int FRAME   = 20;
  localparam int LOCK_TO = 10;

  logic                 clk_100MHz = 1'b0;
  logic                 reset = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*DB-1:0]   req_data = '0;
  logic [NREQ-1:0]      req_last = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 tx_start;
  logic [DB-1:0]        tx_data;
  logic                 tx_ready;
  logic [NREQ-1:0]      grant;
  logic                 locked;

  int n_assert = 0;
  int n_fail   = 0;
  int busy_cnt;

  always #5 clk_100MHz = ~clk_100MHz;

  uart_tx_arbiter #(
    .NREQ         (NREQ),
    .DBITS        (DB),
    .LOCK_TIMEOUT (LOCK_TO)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .grant      (grant),
    .locked     (locked)
  );

  // Transmitter stand-in: busy for FRAME cycles starting the cycle after tx_start.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset)                          busy_cnt <= 0;
    else if (tx_start && busy_cnt == 0) busy_cnt <= FRAME;
    else if (busy_cnt > 0)              busy_cnt <= busy_cnt - 1;
  end
  assign tx_ready = (busy_cnt == 0);

  // Reference model state (transaction level, in cycle numbers).
  int            c, last, next_free, issue_cyc, acc_cyc, acc_w, lock_cnt;
  bit            mlocked;
  logic [DB-1:0] exp_byte;
  logic [DB-1:0] vbyte [NREQ];
  logic [NREQ-1:0] mvalid, mlast, extra;
  bit            lastq [NREQ][$];
  int            obs_log[$];
  int            obs_cyc[$];
  int            exp_order[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    last      = NREQ - 1;
    next_free = c;
    issue_cyc = -100;
    acc_cyc   = -100;
    acc_w     = 0;
    mlocked   = 1'b0;
    lock_cnt  = 0;
  endtask

  task automatic cyc_step(output int acc);
    logic [NREQ-1:0] elig, exp_rdy, exp_gnt, sh;
    int w;
    acc = -1;
    w   = -1;
    #1;
    for (int i = 0; i < NREQ; i++)
      if (req_ready[i]) begin
        obs_log.push_back(i);
        obs_cyc.push_back(c);
      end
    chk("locked", 32'(locked), 32'(mlocked));
    chk("tx_start", 32'(tx_start), 32'(c == issue_cyc));
    if (c == issue_cyc) chk("tx_data", 32'(tx_data), 32'(exp_byte));
    exp_gnt = (c > acc_cyc && c < next_free) ? (NREQ'(1) << acc_w) : '0;
    chk("grant", 32'(grant), 32'(exp_gnt));
    chk("start_while_busy", 32'(tx_start & ~tx_ready), 32'(0));
    exp_rdy = '0;
    if (c >= next_free && tx_ready) begin
      elig = mlocked ? (mvalid & (NREQ'(1) << last)) : mvalid;
      for (int k = 1; k <= NREQ && w < 0; k++) begin
        sh = elig >> ((last + k) % NREQ);
        if (sh[0]) w = (last + k) % NREQ;
      end
      if (w >= 0) begin
        exp_rdy   = NREQ'(1) << w;
        acc       = w;
        acc_w     = w;
        acc_cyc   = c;
        issue_cyc = c + 1;
        next_free = c + FRAME + 3;
        exp_byte  = vbyte[w];
`ifdef UART_TX_ARB_LOCK_EN
        sh       = mlast >> w;
        mlocked  = !sh[0];
        lock_cnt = 0;
`endif
        last = w;
      end
`ifdef UART_TX_ARB_LOCK_EN
      else if (mlocked) begin
        sh = mvalid >> last;
        if (!sh[0]) begin
          lock_cnt++;
          if (lock_cnt == LOCK_TO) begin
            mlocked  = 1'b0;
            lock_cnt = 0;
          end
        end
      end
`endif
    end
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    c++;
  endtask

  task automatic run(input int n);
    int a;
    for (int k = 0; k < n; k++) begin
      @(negedge clk_100MHz);
      for (int i = 0; i < NREQ; i++) begin
        mvalid[i] = (lastq[i].size() > 0) | extra[i];
        mlast[i]  = (lastq[i].size() > 0) ? lastq[i][0] : 1'b1;
        req_data[i*DB +: DB] = vbyte[i];
      end
      req_valid = mvalid;
      req_last  = mlast;
      cyc_step(a);
      if (a >= 0) begin
        if (lastq[a].size() > 0) void'(lastq[a].pop_front());
        vbyte[a] = DB'($urandom);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk_100MHz);
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) lastq[i].delete();
    extra     = '0;
    mvalid    = '0;
    req_valid = '0;
    req_last  = '0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_tx_start", 32'(tx_start), 32'(0));
    chk("rst_tx_data", 32'(tx_data), 32'(0));
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_locked", 32'(locked), 32'(0));
    @(negedge clk_100MHz);
    @(negedge clk_100MHz);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic chk_order(input string tag);
    chk({tag, "_count"}, 32'(obs_log.size()), 32'(exp_order.size()));
    for (int k = 0; k < exp_order.size(); k++)
      chk(tag, (obs_log.size() > k) ? 32'(obs_log[k]) : 32'hFFFF_FFFF, 32'(exp_order[k]));
  endtask

  initial begin
    int r;
    c = 0;
    for (int i = 0; i < NREQ; i++) vbyte[i] = DB'($urandom);
    do_reset();

    // Single request from requester 2 carrying 0xA5.
    obs_log.delete();
    vbyte[2] = 8'hA5;
    lastq[2].push_back(1'b1);
    run(FRAME + 10);
    exp_order = '{2};
    chk_order("single");

    // Fairness from reset: two bytes each, all valid together.
    do_reset();
    obs_log.delete();
    for (int i = 0; i < NREQ; i++) begin
      lastq[i].push_back(1'b1);
      lastq[i].push_back(1'b1);
    end
    run(8 * (FRAME + 3) + 5);
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk_order("fair");

    // Withdrawal: requester 1 valid only while requester 0's frame is in flight.
    obs_log.delete();
    lastq[0].push_back(1'b1);
    run(3);
    extra = 4'b0010;
    run(5);
    extra = '0;
    run(FRAME + 5);
    exp_order = '{0};
    chk_order("withdraw");
    chk("withdraw_grant", 32'(grant), 32'(0));
    chk("withdraw_ready", 32'(req_ready), 32'(0));

    // Reset while waiting for the frame to finish, then all requesters compete.
    lastq[1].push_back(1'b1);
    run(8);
    do_reset();
    obs_log.delete();
    for (int i = 0; i < NREQ; i++) lastq[i].push_back(1'b1);
    run(3);
    exp_order = '{0};
    chk_order("post_reset");
    run(4 * (FRAME + 3) + 5);

    // Random traffic with sparse spurious/withdrawn valids.
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(NREQ - 1, 0);
      lastq[r].push_back(bit'($urandom_range(1, 0)));
      extra = NREQ'($urandom & $urandom & $urandom);
      run($urandom_range(15, 3));
    end
    extra = '0;
    run(1200);
    chk("drain_grant", 32'(grant), 32'(0));

`ifdef UART_TX_ARB_LOCK_EN
    // Packet lock: requester 3 sends three bytes back-to-back while requester 0 waits.
    do_reset();
    lastq[2].push_back(1'b1);
    run(FRAME + 5);
    obs_log.delete();
    lastq[3].push_back(1'b0);
    lastq[3].push_back(1'b0);
    lastq[3].push_back(1'b1);
    lastq[0].push_back(1'b1);
    run(4 * (FRAME + 3) + 5);
    exp_order = '{3, 3, 3, 0};
    chk_order("lock");

    // Lock timeout: requester 2 goes silent mid-packet; requester 1 gets in after the timeout.
    do_reset();
    obs_log.delete();
    obs_cyc.delete();
    lastq[2].push_back(1'b0);
    run(2);
    lastq[1].push_back(1'b1);
    run(FRAME + 3 + LOCK_TO + 5);
    exp_order = '{2, 1};
    chk_order("lock_timeout");
    chk("lock_timeout_gap", (obs_cyc.size() > 1) ? 32'(obs_cyc[1] - obs_cyc[0]) : 32'hFFFF_FFFF,
        32'(FRAME + 3 + LOCK_TO));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
